// File: rtl/lfsr_encrypt_engine_pkg.sv
// Shared types and constants for the LFSR message cipher: FSM states, memory map,
// message framing limits and the legal tap set.
package lfsr_cipher_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_PRE,
    LD_TAP,
    LD_SEED,
    RD,
    WR,
    DONE
  } state_e;

  localparam logic [7:0] MSG_BASE = 8'd0;
  localparam logic [7:0] CFG_BASE = 8'd61;
  localparam logic [7:0] CT_BASE  = 8'd64;

  localparam int PRE_MIN = 10;
  localparam int MSG_MAX = 52;
  localparam int NBYTES  = 64;

  localparam logic [6:0] LEGAL_TAPS [9] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  // True when ciphertext slot idx carries a message byte rather than preamble/pad.
  function automatic logic in_msg(input logic [5:0] idx, input logic [3:0] pre);
    logic [6:0] lo;
    logic [6:0] hi;
    lo = {3'b000, pre};
    hi = lo + 7'(MSG_MAX);
    return ({1'b0, idx} >= lo) && ({1'b0, idx} < hi);
  endfunction

  function automatic logic [7:0] msg_addr(input logic [5:0] idx, input logic [3:0] pre);
    logic [5:0] off;
    off = idx - {2'b00, pre};
    return in_msg(idx, pre) ? (MSG_BASE + {2'b00, off}) : 8'h00;
  endfunction

endpackage

// File: rtl/lfsr_encrypt_engine_if.sv
// Launch handshake plus data-memory port between the encrypt engine and its surroundings.
interface lfsr_encrypt_engine_if;
  logic       Start;
  logic       Ack;
  logic [7:0] MemAddr;
  logic [7:0] MemRdData;
  logic       MemWrEn;
  logic [7:0] MemWrData;

  // The engine is the memory master; the slave side is the core/memory/bench.
  modport master (
    input  Start, MemRdData,
    output Ack, MemAddr, MemWrEn, MemWrData
  );

  modport slave (
    output Start, MemRdData,
    input  Ack, MemAddr, MemWrEn, MemWrData
  );
endinterface

// File: rtl/lfsr_encrypt_engine_lfsr7.sv
// 7-bit Fibonacci-style LFSR with seed load (zero seed forced to 1) and tap-driven step.
module lfsr7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [6:0] seed_i,
  input  logic [6:0] taps_i,
  output logic [6:0] state_o
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  always_comb begin
    // NOTE: default first so every path assigns lfsr_d and no latch is inferred.
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == 7'h00) ? 7'h01 : seed_i;
    end else if (step_i) begin
      lfsr_d = {lfsr_q[5:0], ^(lfsr_q & taps_i)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 7'h00;
    else     lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// Memory-mastering encryptor: reads config and plaintext, writes 64 parity-tagged
// LFSR-whitened bytes at CT_BASE. All outputs are registered off the FSM.
module lfsr_encrypt_engine
  import lfsr_cipher_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  lfsr_encrypt_engine_if.master bus
);

  state_e     state_q;
  logic [5:0] i_q;
  logic [3:0] pre_q;
  logic [6:0] taps_q;
  logic       ack_q;
  logic       we_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;

  logic [6:0] lfsr;
  logic [3:0] pre_d;
  logic [7:0] pt_byte;
  logic [6:0] p_d;
  logic [6:0] c_d;

  lfsr7 u_lfsr (
    .clk     (Clk),
    .rst     (Reset),
    .load_i  (state_q == LD_SEED && !bus.Start),
    .step_i  (state_q == WR && !bus.Start),
    .seed_i  (bus.MemRdData[6:0]),
    .taps_i  (taps_q),
    .state_o (lfsr)
  );

  always_comb begin
    pre_d   = (bus.MemRdData[3:0] < 4'(PRE_MIN)) ? 4'(PRE_MIN) : bus.MemRdData[3:0];
    // Preamble and trailing pad slots encrypt a space.
    pt_byte = in_msg(i_q, pre_q) ? bus.MemRdData : 8'h20;
    p_d     = 7'(pt_byte - 8'h20);
    c_d     = p_d ^ lfsr;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      pre_q   <= '0;
      taps_q  <= '0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (bus.Start) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          state_q <= LD_PRE;
          addr_q  <= CFG_BASE;
        end
        LD_PRE: begin
          pre_q   <= pre_d;
          addr_q  <= CFG_BASE + 8'd1;
          state_q <= LD_TAP;
        end
        LD_TAP: begin
          taps_q  <= bus.MemRdData[6:0];
          addr_q  <= CFG_BASE + 8'd2;
          i_q     <= '0;
          state_q <= LD_SEED;
        end
        LD_SEED: begin
          addr_q  <= msg_addr(6'd0, pre_q);
          state_q <= RD;
        end
        RD: begin
          wdata_q <= {^c_d, c_d};
          addr_q  <= CT_BASE + {2'b00, i_q};
          we_q    <= 1'b1;
          state_q <= WR;
        end
        WR: begin
          we_q <= 1'b0;
          i_q  <= i_q + 6'd1;
          if (i_q == 6'(NBYTES - 1)) begin
            addr_q  <= '0;
            state_q <= DONE;
          end else begin
            addr_q  <= msg_addr(i_q + 6'd1, pre_q);
            state_q <= RD;
          end
        end
        DONE: begin
          ack_q  <= 1'b1;
          addr_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Ack       = ack_q;
  assign bus.MemAddr   = addr_q;
  assign bus.MemWrEn   = we_q;
  assign bus.MemWrData = wdata_q;

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Self-checking bench for lfsr_encrypt_engine: behavioural memory, reference cipher
// model feeding a write scoreboard, plus abort, reset and hold scenarios.
module tb_lfsr_encrypt_engine;
  import lfsr_cipher_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  lfsr_encrypt_engine_if bus ();

  lfsr_encrypt_engine dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  assign bus.MemRdData = mem[bus.MemAddr];
  always @(posedge Clk) if (bus.MemWrEn) mem[bus.MemAddr] <= bus.MemWrData;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        sb_q [$];
  wr_t        sb_e;
  int         wr_cnt  = 0;
  logic       prev_we = 1'b0;
  logic [7:0] msg_buf [52];
  logic [7:0] exp_img [64];
  logic [7:0] img_ref [64];

  // Write monitor: every strobe must match the next expected write.
  always @(negedge Clk) begin
    if (bus.MemWrEn === 1'b1) begin
      wr_cnt++;
      if (prev_we) check("we_back_to_back", 32'd1, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'(bus.MemAddr), 32'hFFFF_FFFF);
      end else begin
        sb_e = sb_q.pop_front();
        check("wr_addr", 32'(bus.MemAddr), 32'(sb_e.addr));
        check("wr_data", 32'(bus.MemWrData), 32'(sb_e.data));
      end
    end
    prev_we = bus.MemWrEn;
  end

  function automatic logic [7:0] padded(input int k, input logic [3:0] pe);
    if (k >= int'(pe) && k < int'(pe) + 52) return msg_buf[k - int'(pe)];
    return 8'h20;
  endfunction

  task automatic load_mem(input string msg, input logic [7:0] pre_b, taps_b, seed_b);
    for (int k = 0; k < 52; k++) msg_buf[k] = (k < msg.len()) ? msg[k] : 8'h20;
    for (int k = 0; k < 52; k++) mem[k] = msg_buf[k];
    for (int k = 52; k < 61; k++) mem[k] = 8'h00;
    mem[61] = pre_b;
    mem[62] = taps_b;
    mem[63] = seed_b;
    for (int k = 64; k < 128; k++) mem[k] = 8'h00;
  endtask

  // Reference encryption; also queues the expected write stream.
  task automatic build_model(input logic [7:0] pre_b, taps_b, seed_b);
    logic [3:0] pe;
    logic [6:0] lf, p, c;
    pe = (pre_b[3:0] < 4'd10) ? 4'd10 : pre_b[3:0];
    lf = (seed_b[6:0] == 7'h00) ? 7'h01 : seed_b[6:0];
    for (int k = 0; k < 64; k++) begin
      p = 7'(padded(k, pe) - 8'h20);
      c = p ^ lf;
      exp_img[k] = {^c, c};
      sb_q.push_back('{addr: 8'(64 + k), data: {^c, c}});
      lf = {lf[5:0], ^(lf & taps_b[6:0])};
    end
  endtask

  task automatic decrypt_check(input string tag, input logic [7:0] pre_b, taps_b, seed_b);
    logic [3:0] pe;
    logic [6:0] lf, p;
    int errs;
    errs = 0;
    pe = (pre_b[3:0] < 4'd10) ? 4'd10 : pre_b[3:0];
    lf = (seed_b[6:0] == 7'h00) ? 7'h01 : seed_b[6:0];
    for (int k = 0; k < 64; k++) begin
      if (^exp_img[k] != 1'b0) errs++;
      p = exp_img[k][6:0] ^ lf;
      if ({1'b0, p} + 8'h20 != padded(k, pe)) errs++;
      lf = {lf[5:0], ^(lf & taps_b[6:0])};
    end
    check({tag, "_decrypt"}, 32'(errs), 32'd0);
  endtask

  function automatic int diff_vs_model();
    int d;
    d = 0;
    for (int k = 0; k < 64; k++) if (mem[64 + k] !== exp_img[k]) d++;
    return d;
  endfunction

  function automatic int diff_vs_ref();
    int d;
    d = 0;
    for (int k = 0; k < 64; k++) if (mem[64 + k] !== img_ref[k]) d++;
    return d;
  endfunction

  task automatic save_ref();
    for (int k = 0; k < 64; k++) img_ref[k] = mem[64 + k];
  endtask

  task automatic run_full(input string tag, input string msg, input logic [7:0] pre_b, taps_b, seed_b);
    int n, w0;
    load_mem(msg, pre_b, taps_b, seed_b);
    build_model(pre_b, taps_b, seed_b);
    decrypt_check(tag, pre_b, taps_b, seed_b);
    w0 = wr_cnt;
    @(negedge Clk) bus.Start = 1'b0;
    @(posedge Clk);
    n = 0;
    while (bus.Ack !== 1'b1 && n < 300) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check({tag, "_ack_latency"}, 32'(n), 32'd132);
    check({tag, "_writes"}, 32'(wr_cnt - w0), 32'd64);
    check({tag, "_sb_drain"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_image"}, 32'(diff_vs_model()), 32'd0);
    @(negedge Clk) bus.Start = 1'b1;
    @(posedge Clk);
    #1;
    check({tag, "_ack_drop"}, 32'(bus.Ack), 32'd0);
    sb_q.delete();
  endtask

  localparam string MSG = "Mr. Watson, come here. I want to see you.";

  initial begin
    logic [7:0] golden [7];
    int w0;
    bit hit;
    int bad;
    golden = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'h41};

    bus.Start = 1'b1;
    Reset     = 1'b1;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    repeat (2) @(negedge Clk);
    check("rst_ack", 32'(bus.Ack), 32'd0);
    check("rst_we", 32'(bus.MemWrEn), 32'd0);
    check("rst_addr", 32'(bus.MemAddr), 32'd0);
    check("rst_wdata", 32'(bus.MemWrData), 32'd0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("idle_addr", 32'(bus.MemAddr), 32'd0);

    // Known-answer vector: spaces, pre 10, taps 0x60, seed 1.
    run_full("kat", "", 8'd10, 8'h60, 8'h01);
    for (int k = 0; k < 7; k++) check($sformatf("kat_mem%0d", 64 + k), 32'(mem[64 + k]), 32'(golden[k]));
    save_ref();

    run_full("seed0", "", 8'd10, 8'h60, 8'h00);
    check("seed0_eq_seed1", 32'(diff_vs_ref()), 32'd0);

    run_full("pre10", MSG, 8'd10, 8'h48, 8'h2B);
    save_ref();
    run_full("pre3", MSG, 8'd3, 8'h48, 8'h2B);
    check("pre3_eq_pre10", 32'(diff_vs_ref()), 32'd0);
    check("msg0_at_74", 32'(mem[74]), 32'(exp_img[10]));

    for (int j = 0; j < 9; j++)
      run_full($sformatf("taps%0d", j), MSG, 8'd15, {1'b0, LEGAL_TAPS[j]}, 8'($urandom_range(0, 127)));

    // Abort with Start while the write of byte 20 is on the bus.
    load_mem(MSG, 8'd12, 8'h6A, 8'h55);
    build_model(8'd12, 8'h6A, 8'h55);
    w0 = wr_cnt;
    @(negedge Clk) bus.Start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(posedge Clk);
      #1;
      if (bus.MemWrEn === 1'b1 && bus.MemAddr == 8'd84) hit = 1'b1;
    end
    check("abort_trigger", 32'(hit), 32'd1);
    bus.Start = 1'b1;
    @(posedge Clk);
    #1;
    check("abort_we", 32'(bus.MemWrEn), 32'd0);
    check("abort_addr", 32'(bus.MemAddr), 32'd0);
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge Clk);
      #1;
      if (bus.MemWrEn !== 1'b0 || bus.Ack !== 1'b0) bad++;
    end
    check("abort_quiet", 32'(bad), 32'd0);
    check("abort_writes", 32'(wr_cnt - w0), 32'd21);
    sb_q.delete();
    run_full("relaunch", MSG, 8'd12, 8'h6A, 8'h55);

    // Asynchronous reset in the middle of the WR cycle for byte 5.
    load_mem(MSG, 8'd10, 8'h7B, 8'h11);
    build_model(8'd10, 8'h7B, 8'h11);
    @(negedge Clk) bus.Start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(posedge Clk);
      #1;
      if (bus.MemWrEn === 1'b1 && bus.MemAddr == 8'd69) hit = 1'b1;
    end
    check("reset_trigger", 32'(hit), 32'd1);
    #2 Reset = 1'b1;
    bus.Start = 1'b1;
    #1;
    check("reset_we", 32'(bus.MemWrEn), 32'd0);
    check("reset_ack", 32'(bus.Ack), 32'd0);
    check("reset_addr", 32'(bus.MemAddr), 32'd0);
    @(posedge Clk);
    #1;
    check("reset_no_commit", 32'(mem[69]), 32'd0);
    sb_q.delete();
    @(negedge Clk) Reset = 1'b0;

    // Start held high: no activity at all.
    w0 = wr_cnt;
    repeat (50) @(negedge Clk);
    check("hold_writes", 32'(wr_cnt - w0), 32'd0);
    check("hold_ack", 32'(bus.Ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
